lut_key_search: RTL

//  Reverse of the key->data selector: a writable table of NR_KEY (key,data) pairs searched by

---
 rtl/lut_key_search.sv | 126 ++++++++++++
 1 files changed

// File: rtl/lut_key_search.sv
// lut_key_search: reverse lookup table. Holds NR_KEY {valid,key,data} entries and
// searches them by data value, one entry per cycle starting at index 0, returning
// the key of the lowest-index valid match (or a miss value) over a valid/ready handshake.
module lut_key_search #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 8,
  parameter int DATA_LEN    = 8,
  parameter bit HAS_DEFAULT = 1'b0,
  localparam int IDX_W      = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr_all,
  input  logic [KEY_LEN-1:0]  default_key,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_hit,
  output logic [KEY_LEN-1:0]  resp_key,
  output logic [IDX_W-1:0]    resp_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NR_KEY - 1);
  localparam logic [IDX_W:0]   NR_KEY_EXT = (IDX_W + 1)'(NR_KEY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_RESP
  } state_t;

  state_t                state;
  logic [NR_KEY-1:0]     vld;
  logic [KEY_LEN-1:0]    key_tab  [NR_KEY];
  logic [DATA_LEN-1:0]   data_tab [NR_KEY];
  logic [IDX_W-1:0]      scan_idx;
  logic [DATA_LEN-1:0]   req_lat;
  logic                  wr_in_range;
  logic                  entry_match;

  // Writes to indices past the table end are dropped rather than aliased.
  assign wr_in_range = ({1'b0, wr_idx} < NR_KEY_EXT);

  // The entry under the scan pointer matches only if it is valid; stale data in
  // invalidated entries must never produce a hit.
  assign entry_match = vld[scan_idx] && (data_tab[scan_idx] == req_lat);

  // Table storage: clr_all invalidates everything and takes priority over a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        key_tab[i]  <= '0;
        data_tab[i] <= '0;
      end
    end else if (clr_all) begin
      vld <= '0;
    end else if (wr_en && wr_in_range) begin
      vld[wr_idx]      <= 1'b1;
      key_tab[wr_idx]  <= wr_key;
      data_tab[wr_idx] <= wr_data;
    end
  end

  // Search FSM with registered handshake outputs; a reset at any point drops the
  // scan and any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      scan_idx   <= '0;
      req_lat    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_key   <= '0;
      resp_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_lat   <= req_data;
            scan_idx  <= '0;
            req_ready <= 1'b0;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (entry_match) begin
            resp_hit   <= 1'b1;
            resp_key   <= key_tab[scan_idx];
            resp_idx   <= scan_idx;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (scan_idx == LAST_IDX) begin
            resp_hit   <= 1'b0;
            resp_key   <= HAS_DEFAULT ? default_key : '0;
            resp_idx   <= '0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
